// File: rtl/reg_to_mem_store.sv
// Store buffer between EX/MEM and data memory: aligns SB/SH/SW big-endian at push and
// drains entries over mem_req/mem_ack. Optional trap on misaligned stores: MISALIGN_TRAP_EN.
module reg_to_mem_store #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          st_valid,
  output logic          st_ready,
  input  logic [1:0]    st_size,
  input  logic [AW-1:0] st_addr,
  input  logic [31:0]   st_data,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_be,
  input  logic          mem_ack,
  output logic          sb_empty,
  output logic          st_misalign,
  output logic          dbg_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  // Handshakes: a store transfers when st_valid && st_ready at a rising edge; a memory
  // write completes when mem_req && mem_ack at a rising edge. mem_ack with mem_req=0 is ignored.

  state_t        state;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] nxt_ptr;
  logic [CW-1:0] count;

  logic [AW-1:0] addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [3:0]    be_q   [DEPTH];

  logic [AW-1:0] in_addr;
  logic [31:0]   in_data;
  logic [3:0]    in_be;
  logic          accept;
  logic          push;
  logic          pop;

  assign st_ready  = (count != CW'(DEPTH));
  assign sb_empty  = (count == '0);
  assign accept    = st_valid && st_ready;
  assign pop       = (state == REQ) && mem_ack;
  assign nxt_ptr   = rd_ptr + 1'b1;
  assign dbg_state = (state == REQ);

  // Big-endian lanes: byte offset 0 lives in bits 31:24 (be[3]).
  always_comb begin
    in_addr = {st_addr[AW-1:2], 2'b00};
    in_be   = 4'b1111;
    in_data = st_data;
    case (st_size)
      2'b00: begin
        in_be   = 4'b1000 >> st_addr[1:0];
        in_data = {4{st_data[7:0]}};
      end
      2'b01: begin
        in_be   = st_addr[1] ? 4'b0011 : 4'b1100;
        in_data = {2{st_data[15:0]}};
      end
      default: begin
        in_be   = 4'b1111;
        in_data = st_data;
      end
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = ((st_size == 2'b01) && st_addr[0]) ||
                      (st_size[1] && (st_addr[1:0] != 2'b00));
  assign push = accept && !misaligned;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_misalign <= 1'b0;
    else        st_misalign <= accept && misaligned;
  end
`else
  assign push        = accept;
  assign st_misalign = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= in_addr;
      data_q[wr_ptr] <= in_data;
      be_q[wr_ptr]   <= in_be;
    end
  end

  // The in-flight write stays at the FIFO head until acked, so count covers it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= nxt_ptr;

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      case (state)
        IDLE: begin
          if (count != '0) begin
            mem_addr  <= addr_q[rd_ptr];
            mem_wdata <= data_q[rd_ptr];
            mem_be    <= be_q[rd_ptr];
            mem_req   <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (mem_ack) begin
            if (count > CW'(1)) begin
              mem_addr  <= addr_q[nxt_ptr];
              mem_wdata <= data_q[nxt_ptr];
              mem_be    <= be_q[nxt_ptr];
            end else if (push) begin
              // Entry arriving on the same edge the last one drains: forward it directly.
              mem_addr  <= in_addr;
              mem_wdata <= in_data;
              mem_be    <= in_be;
            end else begin
              mem_req <= 1'b0;
              state   <= IDLE;
            end
          end
        end
        default: begin
          mem_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_to_mem_store.sv
// Bench for reg_to_mem_store: directed scenarios plus random traffic against a queue model
// of expected memory writes. Honours MISALIGN_TRAP_EN when defined.
module tb_reg_to_mem_store;

  localparam int DEPTH = 4;
  localparam int AW    = 32;

  logic          clk;
  logic          rst_n;
  logic          st_valid;
  logic          st_ready;
  logic [1:0]    st_size;
  logic [AW-1:0] st_addr;
  logic [31:0]   st_data;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_be;
  logic          mem_ack;
  logic          sb_empty;
  logic          st_misalign;
  logic          dbg_state;

  reg_to_mem_store #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .st_valid    (st_valid),
    .st_ready    (st_ready),
    .st_size     (st_size),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_be      (mem_be),
    .mem_ack     (mem_ack),
    .sb_empty    (sb_empty),
    .st_misalign (st_misalign),
    .dbg_state   (dbg_state)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: {addr[31:0], be[3:0], wdata[31:0]} of writes still owed to memory
  logic [67:0] exp_q[$];
  int          n_vec;
  int          n_bad;
  int          stall;
  logic        exp_mis;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic is_misaligned(input logic [1:0] sz, input logic [31:0] a);
    int off;
    off = int'(a[1:0]);
    if (sz == 2'b01) return (off % 2) != 0;
    if (sz[1])       return off != 0;
    return 1'b0;
  endfunction

  // Lane-by-lane model of the memory write a store should produce.
  function automatic logic [67:0] expect_write(input logic [1:0] sz, input logic [31:0] a,
                                               input logic [31:0] d);
    int         off, start, len;
    logic [3:0] be;
    logic [31:0] wd;
    off = int'(a[1:0]);
    if (sz == 2'b00)      begin start = off;           len = 1; end
    else if (sz == 2'b01) begin start = (off / 2) * 2; len = 2; end
    else                  begin start = 0;             len = 4; end
    be = 4'b0000;
    wd = 32'h0;
    for (int l = 0; l < 4; l++) begin
      if (l >= start && l < start + len) be[3-l] = 1'b1;
      if (sz == 2'b00)      wd[31-8*l -: 8] = d[7:0];
      else if (sz == 2'b01) wd[31-8*l -: 8] = (l % 2 == 0) ? d[15:8] : d[7:0];
      else                  wd[31-8*l -: 8] = d[31-8*l -: 8];
    end
    return {a[31:2], 2'b00, be, wd};
  endfunction

  task automatic check_outputs();
    check("st_ready", 64'(st_ready), 64'(exp_q.size() < DEPTH));
    check("sb_empty", 64'(sb_empty), 64'(exp_q.size() == 0));
    check("st_misalign", 64'(st_misalign), 64'(exp_mis));
    if (exp_q.size() == 0) begin
      stall = 0;
      check("req_idle", 64'(mem_req), 64'(0));
    end else begin
      if (!mem_req) stall++;
      else          stall = 0;
      check("req_live", 64'(stall <= 1), 64'(1));
      if (mem_req) begin
        check("mem_addr",  64'(mem_addr),  64'(exp_q[0][67:36]));
        check("mem_be",    64'(mem_be),    64'(exp_q[0][35:32]));
        check("mem_wdata", 64'(mem_wdata), 64'(exp_q[0][31:0]));
      end
    end
  endtask

  // driver: one clock cycle, entered and left just after a falling edge
  task automatic step(input logic v, input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] d, input logic ack);
    logic acc, cmp;
    st_valid = v;
    st_size  = sz;
    st_addr  = a;
    st_data  = d;
    mem_ack  = ack;
    acc = v && (exp_q.size() < DEPTH);
    cmp = mem_req && ack;
    @(posedge clk);
    if (cmp && exp_q.size() > 0) void'(exp_q.pop_front());
`ifdef MISALIGN_TRAP_EN
    exp_mis = acc && is_misaligned(sz, a);
    if (acc && !is_misaligned(sz, a)) exp_q.push_back(expect_write(sz, a, d));
`else
    exp_mis = 1'b0;
    if (acc) exp_q.push_back(expect_write(sz, a, d));
`endif
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input logic ack, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'b10, 32'h0, 32'h0, ack);
  endtask

  initial begin
    n_vec    = 0;
    n_bad    = 0;
    stall    = 0;
    exp_mis  = 1'b0;
    rst_n    = 1'b0;
    st_valid = 1'b0;
    st_size  = 2'b00;
    st_addr  = '0;
    st_data  = '0;
    mem_ack  = 1'b0;

    #12;
    check("rst_mem_req",   64'(mem_req),     64'(0));
    check("rst_mem_addr",  64'(mem_addr),    64'(0));
    check("rst_mem_wdata", 64'(mem_wdata),   64'(0));
    check("rst_mem_be",    64'(mem_be),      64'(0));
    check("rst_misalign",  64'(st_misalign), 64'(0));
    check("rst_st_ready",  64'(st_ready),    64'(1));
    check("rst_sb_empty",  64'(sb_empty),    64'(1));
    @(negedge clk);
    rst_n = 1'b1;
    idle(1'b0, 2);

    // single SW with ack held high
    step(1'b1, 2'b10, 32'h100, 32'hDEADBEEF, 1'b1);
    check("t1_latency", 64'(mem_req), 64'(0));
    step(1'b0, 2'b10, 32'h0, 32'h0, 1'b1);
    check("t1_req", 64'(mem_req), 64'(1));
    check("t1_be", 64'(mem_be), 64'(4'b1111));
    step(1'b0, 2'b10, 32'h0, 32'h0, 1'b1);
    check("t1_done_req", 64'(mem_req), 64'(0));
    check("t1_done_empty", 64'(sb_empty), 64'(1));

    // SB and SH alignment
    step(1'b1, 2'b00, 32'h203, 32'h000000A5, 1'b0);
    step(1'b1, 2'b01, 32'h202, 32'h00001234, 1'b0);
    check("t2_sb_addr", 64'(mem_addr), 64'(32'h200));
    check("t2_sb_be", 64'(mem_be), 64'(4'b0001));
    check("t2_sb_wdata", 64'(mem_wdata), 64'(32'hA5A5A5A5));
    step(1'b0, 2'b10, 32'h0, 32'h0, 1'b1);
    check("t2_sh_be", 64'(mem_be), 64'(4'b0011));
    check("t2_sh_wdata", 64'(mem_wdata), 64'(32'h12341234));
    idle(1'b1, 2);

    // fill with ack low, then burst drain
    for (int i = 0; i < 5; i++) step(1'b1, 2'b10, 32'h400 + 32'(4*i), 32'h1000 + 32'(i), 1'b0);
    check("t3_full", 64'(st_ready), 64'(0));
    idle(1'b0, 2);
    for (int i = 0; i < 4; i++) begin
      check("t3_burst", 64'(mem_req), 64'(1));
      check("t3_order", 64'(mem_addr), 64'(32'h400 + 32'(4*i)));
      step(1'b0, 2'b10, 32'h0, 32'h0, 1'b1);
    end
    check("t3_drained", 64'(mem_req), 64'(0));

    // push on the same edge the last entry is acked
    step(1'b1, 2'b10, 32'h500, 32'h55555555, 1'b0);
    step(1'b0, 2'b10, 32'h0, 32'h0, 1'b0);
    step(1'b1, 2'b10, 32'h504, 32'h66666666, 1'b1);
    check("t4_req_held", 64'(mem_req), 64'(1));
    check("t4_not_empty", 64'(sb_empty), 64'(0));
    check("t4_new_addr", 64'(mem_addr), 64'(32'h504));
    idle(1'b1, 2);

    // misaligned word
    step(1'b1, 2'b10, 32'h102, 32'hCAFEF00D, 1'b0);
    step(1'b0, 2'b10, 32'h0, 32'h0, 1'b0);
`ifdef MISALIGN_TRAP_EN
    check("t5_no_req", 64'(mem_req), 64'(0));
`else
    check("t5_addr", 64'(mem_addr), 64'(32'h100));
    check("t5_be", 64'(mem_be), 64'(4'b1111));
`endif
    idle(1'b1, 2);

    // reset in the middle of a request with 3 entries buffered
    for (int i = 0; i < 3; i++) step(1'b1, 2'b10, 32'h600 + 32'(4*i), 32'h77 + 32'(i), 1'b0);
    check("t6_pre_req", 64'(mem_req), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("t6_req_drop", 64'(mem_req), 64'(0));
    check("t6_empty", 64'(sb_empty), 64'(1));
    check("t6_ready", 64'(st_ready), 64'(1));
    exp_q.delete();
    exp_mis = 1'b0;
    stall = 0;
    mem_ack = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    idle(1'b1, 4);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
           2'($urandom_range(0, 3)),
           $urandom & 32'h3FF,
           $urandom,
           ($urandom_range(0, 9) < 5) ? 1'b1 : 1'b0);
    end
    idle(1'b1, 2 * DEPTH + 2);
    check("final_empty", 64'(sb_empty), 64'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
